wb_stage_ext: RTL
=================

Name: wb_stage_ext

Overview:
Parametrised writeback pipeline stage for the RV32I core, and the successor to the fixed three-way writeback register. It selects the writeback source, extracts and sign- or zero-extends sub-word load data, and suppresses writes to x0. It supports pipeline stall and flush and flags misaligned loads. It also keeps a retired-instruction counter for the CSR unit. The block sits between the MEM stage and the register file and has one cycle of latency.

Parameters:
REG_ADDR_W, 5, width of the register index (rd_in, rd_out).
PC_STEP, 4, increment added to pc_in for link writeback (JAL/JALR).
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
valid_in  input  1  MEM stage presents a live instruction.
stall  input  1  hold all outputs and the counter this cycle.
flush  input  1  kill the instruction being captured.
pc_in  input  32  PC of the instruction.
alu_result_in  input  32  ALU result; also the load byte address.
mem_data_in  input  32  aligned 32-bit word read from data memory.
imm_in  input  32  U-type immediate (LUI).
funct3_in  input  3  load size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
rd_in  input  REG_ADDR_W  destination register.
wb_sel  input  3  source: 000 ALU, 001 load, 010 PC+PC_STEP, 011 imm, others zero.
reg_write_in  input  1  instruction writes rd.
reg_data_out  output  32  registered writeback data.
rd_out  output  REG_ADDR_W  registered destination register.
reg_write_out  output  1  registered register-file write enable.
valid_out  output  1  a retired instruction is present this cycle.
misalign_out  output  1  the retired load was misaligned; the write was suppressed.
instret_out  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst=1): all outputs are 0, including instret_out. Reset has priority over every other input. Deasserting reset mid-stream leaves all outputs at 0 until the next capture.
- Per-edge priority: rst > stall > flush > capture.
- stall=1: every output register and the counter hold, regardless of flush or valid_in.
- flush=1 (stall=0): valid_out, reg_write_out and misalign_out go to 0. reg_data_out and rd_out hold. The counter does not increment.
- Capture (stall=0, flush=0): all outputs update one cycle after the inputs are presented.
  - valid_out <= valid_in.
  - rd_out <= rd_in.
  - reg_data_out <= the selected source. For wb_sel values 100-111 it is 0.
  - PC link value = pc_in + PC_STEP, truncated to 32 bits, so 0xFFFFFFFC+4 wraps to 0x00000000.
- Load extraction (wb_sel=001). The offset is alu_result_in[1:0].
  - LB/LBU: take byte[offset] = mem_data_in[8*offset+7 : 8*offset]. LB sign-extends it; LBU zero-extends it.
  - LH/LHU: take the halfword selected by offset[1]. LH sign-extends it; LHU zero-extends it. offset[0]=1 is misaligned.
  - LW: takes the full word. offset != 00 is misaligned.
  - Any other funct3 value gives data 0 and is not treated as misaligned.
- Misalign condition: valid_in & wb_sel=001 & misaligned. When true, misalign_out <= 1 and reg_write_out <= 0. reg_data_out takes the extracted value and is don't-care to consumers.
- reg_write_out <= valid_in & reg_write_in & (rd_in != 0) & ~misalign.
  - Writes to x0 are never issued.
  - An instruction with valid_in=0 never writes, whatever reg_write_in is.
- instret counter: increments by 1 on a capture edge with valid_in=1. A misaligned load still retires and counts. The counter wraps from all-ones to 0. instret_out is the registered count, so it reflects the increment one cycle after the instruction is presented.
- Simultaneous valid_in and flush: the instruction is dropped and not counted.

Test Plan:
1. rst=1 with random inputs, then release -> all outputs 0. Pulse rst for one cycle while streaming instructions -> outputs clear immediately, without waiting for a clock edge.
2. ALU, PC and LUI writeback:
   - wb_sel=000, alu=0x12345678, rd=5 -> next cycle reg_data_out=0x12345678, rd_out=5, reg_write_out=1, instret_out=1.
   - wb_sel=010, pc=0x100 -> 0x104.
   - wb_sel=010, pc=0xFFFFFFFC -> 0x00000000.
   - wb_sel=011, imm=0xABCDE000 -> 0xABCDE000.
3. Loads with mem_data_in=0x80FF7F01:
   - LB at offset 2 -> 0xFFFFFFFF.
   - LBU at offset 3 -> 0x00000080.
   - LB at offset 0 -> 0x00000001.
   - LH at offset 2 -> 0xFFFF80FF.
   - LHU at offset 0 -> 0x00007F01.
   - LW at offset 0 -> 0x80FF7F01.
4. Misaligned and x0:
   - LW at offset 1 -> misalign_out=1, reg_write_out=0, valid_out=1, instret increments.
   - LH at offset 3 -> same response.
   - ALU write with rd=0 -> reg_write_out=0, valid_out=1.
5. Stall and flush:
   - Hold stall=1 for 3 cycles while changing the inputs -> outputs and instret are frozen.
   - stall=1 with flush=1 -> still frozen.
   - flush=1 with valid_in=1 -> valid_out=0, reg_write_out=0, instret unchanged.
6. Counter wrap: build with CNT_W=4 and retire 17 valid instructions -> instret_out goes 15, then 0, then 1.

Source files
------------

// File: rtl/wb_stage_ext.sv
// RV32I writeback stage: source select, sub-word load extraction, x0 write suppression,
// misaligned-load flagging and a retired-instruction counter, with one cycle of latency.
module wb_stage_ext #(
    parameter int REG_ADDR_W = 5,
    parameter int PC_STEP    = 4,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           alu_result_in,
    input  logic [31:0]           mem_data_in,
    input  logic [31:0]           imm_in,
    input  logic [2:0]            funct3_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [2:0]            wb_sel,
    input  logic                  reg_write_in,
    output logic [31:0]           reg_data_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write_out,
    output logic                  valid_out,
    output logic                  misalign_out,
    output logic [CNT_W-1:0]      instret_out
);

    // valid_in qualifies a transaction; there is no backpressure, stall simply freezes the stage.
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        ld_mis;
    logic [31:0] sel_data;
    logic        misalign;

    always_comb begin
        off = alu_result_in[1:0];
        case (off)
            2'd0:    ld_byte = mem_data_in[7:0];
            2'd1:    ld_byte = mem_data_in[15:8];
            2'd2:    ld_byte = mem_data_in[23:16];
            default: ld_byte = mem_data_in[31:24];
        endcase
        ld_half = off[1] ? mem_data_in[31:16] : mem_data_in[15:0];

        ld_data = '0;
        ld_mis  = 1'b0;
        case (funct3_in)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {24'b0, ld_byte};
            3'b001: begin
                ld_data = {{16{ld_half[15]}}, ld_half};
                ld_mis  = off[0];
            end
            3'b101: begin
                ld_data = {16'b0, ld_half};
                ld_mis  = off[0];
            end
            3'b010: begin
                ld_data = mem_data_in;
                ld_mis  = (off != 2'b00);
            end
            default: begin
                ld_data = '0;
                ld_mis  = 1'b0;
            end
        endcase

        case (wb_sel)
            3'b000:  sel_data = alu_result_in;
            3'b001:  sel_data = ld_data;
            3'b010:  sel_data = pc_in + 32'(PC_STEP);
            3'b011:  sel_data = imm_in;
            default: sel_data = '0;
        endcase

        misalign = valid_in & (wb_sel == 3'b001) & ld_mis;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_data_out  <= '0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            valid_out     <= 1'b0;
            misalign_out  <= 1'b0;
            instret_out   <= '0;
        end else if (stall) begin
            reg_data_out  <= reg_data_out;
            rd_out        <= rd_out;
            reg_write_out <= reg_write_out;
            valid_out     <= valid_out;
            misalign_out  <= misalign_out;
            instret_out   <= instret_out;
        end else if (flush) begin
            // Data and rd hold so the register file sees no spurious change on a killed slot.
            reg_write_out <= 1'b0;
            valid_out     <= 1'b0;
            misalign_out  <= 1'b0;
        end else begin
            reg_data_out  <= sel_data;
            rd_out        <= rd_in;
            reg_write_out <= valid_in & reg_write_in & (rd_in != '0) & ~misalign;
            valid_out     <= valid_in;
            misalign_out  <= misalign;
            if (valid_in)
                instret_out <= instret_out + CNT_W'(1);
        end
    end

endmodule
